jac_fetch_seq: RTL and testbench
================================

Name: jac_fetch_seq

Overview:
Instruction fetch and sequencing stage that sits directly upstream of the program memory.
- Drives the program-memory address (pc) and captures the combinational instruction word returned (ir).
- Resolves control-flow opcodes (goto, ifz, ifnz, ifeq) locally.
- Issues only data-path instructions to the execute stage through a one-entry issue register with valid/stall handshake.

Parameters:
PC_WIDTH, 8, width of pc and of branch/goto target arithmetic
IRWidth, 16, instruction word width
CMD_CNT, 64, number of implemented program words; legal pc range 0..CMD_CNT-1

Ports:
clk  in  1  system clock, rising edge
res_n  in  1  reset; asynchronous, active-low
ir  in  IRWidth  instruction word from program memory for current pc (combinational)
flag_zero  in  1  registered ALU zero flag
flag_eq  in  1  registered ALU equal flag
exec_stall  in  1  execute stage cannot accept; freezes this stage
pc  out  PC_WIDTH  program-memory address
instr  out  IRWidth  issued instruction to execute stage
instr_pc  out  PC_WIDTH  address of issued instruction
instr_valid  out  1  instr is a valid data-path instruction this cycle
fault  out  1  sticky; branch target out of range

Behaviour:
- Reset values: pc=0, instr=0, instr_pc=0, instr_valid=0, fault=0, state=START. The internal decode register (dq, dq_pc, dq_v) is also cleared.
- Opcode = ir[15:11]; param = ir[7:0].
  - goto = 5'b10000; ifz = 5'b10001; ifnz = 5'b10010; ifeq = 5'b10011.
  - All other opcodes are data-path instructions.
- States:
  - START: one cycle after reset release. No fetch is captured. Goes to RUN. pc stays 0.
  - RUN: normal operation.
  - HALT: entered on fault. pc and outputs are frozen, instr_valid=0. Left only by reset.
- RUN pipeline, two stages: F (pc -> ir) and D (dq).
  - Each non-stalled cycle: dq <= ir, dq_pc <= pc, dq_v <= 1, pc <= pc+1.
  - pc wraps from CMD_CNT-1 to 0.
- D stage:
  - If dq is a data-path instruction: instr <= dq, instr_pc <= dq_pc, instr_valid <= 1 (registered, 1 cycle after capture).
  - If dq is a control instruction: instr_valid <= 0 and the condition is evaluated against flag_zero/flag_eq in that cycle.
    - The execute stage updates flags at the edge ending the predecessor's issue cycle, so the flags already reflect all earlier instructions. No interlock is needed.
- Taken condition (ifz: zero=1; ifnz: zero=0; ifeq: eq=1; goto: always):
  - For goto: target = param.
  - For skips: target = dq_pc + 1 + param, computed mod 2^PC_WIDTH.
  - Then: pc <= target; the word captured in F this cycle is flushed (dq_v <= 0).
  - One bubble per taken control instruction; zero bubbles when not taken.
- If target >= CMD_CNT: fault <= 1, state <= HALT, nothing further is issued.
- Skip with param=0 is taken but equivalent to fall-through (target = dq_pc+1). It still costs one bubble.
- Back-to-back control instructions:
  - If the first is taken, the second is flushed.
  - If not taken, the second is evaluated the next cycle.
- exec_stall=1 holds pc, dq, instr, instr_valid and flag evaluation unchanged. Control decisions are deferred until stall drops.
- A dq_v=0 (bubble) entry issues instr_valid=0.
- Reset asserted at any time returns all state to reset values on the same instant (asynchronous). There is no partial flush.

Decomposition:
- Shared package jac_pkg:
  - opcode localparams (OP_GOTO, OP_IFZ, OP_IFNZ, OP_IFEQ, plus the data-path opcodes)
  - opcode field bit positions
  - state encodings START/RUN/HALT
- One natural sub-module: jac_branch_cond. It is combinational and takes opcode, param, dq_pc, flags. It outputs is_ctrl, taken, target, target_oob.
- The sequencer FSM and the registers remain in jac_fetch_seq.

Test Plan:
1. Reset release, straight-line program (val,val,val,add) -> pc 0,0,1,2,3..., first instr_valid=1 two cycles after START exit with instr_pc=0; no fault.
2. flag_zero=0, ifz skip 2 at pc 10 -> not taken, no bubble; nop at 11 issued with instr_pc=11.
3. flag_zero=0, ifnz skip 3 at pc 15 -> taken, pc loads 19, one bubble, next issued instr_pc=19; 16..18 never issued.
4. goto 8 at pc 27 -> pc=8 next cycle, one bubble, instr_pc=8 issued; repeat loop 3 times with identical sequence.
5. goto 70 (CMD_CNT=64) -> fault=1, HALT, instr_valid stays 0 and pc frozen until res_n low; after reset fault=0, pc=0.
6. exec_stall held 3 cycles with ifeq in D and flag_eq toggling during stall -> no pc change; decision uses flag_eq value in first unstalled cycle; pc=63 non-control -> wraps to 0.

Source files
------------

// File: rtl/jac_pkg.sv
// Shared encodings for the jac fetch/sequencing slice: opcode fields, opcodes and FSM states.
package jac_pkg;

  localparam int unsigned OPC_MSB   = 15;
  localparam int unsigned OPC_LSB   = 11;
  localparam int unsigned OPC_W     = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned PARAM_MSB = 7;
  localparam int unsigned PARAM_LSB = 0;
  localparam int unsigned PARAM_W   = PARAM_MSB - PARAM_LSB + 1;

  // Control-flow opcodes, resolved inside the fetch stage
  localparam logic [OPC_W-1:0] OP_GOTO = 5'b10000;
  localparam logic [OPC_W-1:0] OP_IFZ  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_IFNZ = 5'b10010;
  localparam logic [OPC_W-1:0] OP_IFEQ = 5'b10011;

  // Data-path opcodes, passed through to execute untouched
  localparam logic [OPC_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPC_W-1:0] OP_VAL  = 5'b00001;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00010;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_CMP  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_LOAD = 5'b00101;
  localparam logic [OPC_W-1:0] OP_STOR = 5'b00110;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  function automatic logic is_ctrl_op(input logic [OPC_W-1:0] opc);
    return (opc == OP_GOTO) || (opc == OP_IFZ) || (opc == OP_IFNZ) || (opc == OP_IFEQ);
  endfunction

endpackage

// File: rtl/jac_branch_cond.sv
// Combinational control-flow resolver: classifies the decoded word, evaluates its condition
// and computes the branch target plus an out-of-range indication.
module jac_branch_cond
  import jac_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned CMD_CNT  = 64
) (
  input  logic [OPC_W-1:0]    opcode,
  input  logic [PARAM_W-1:0]  param,
  input  logic [PC_WIDTH-1:0] dq_pc,
  input  logic                flag_zero,
  input  logic                flag_eq,
  output logic                is_ctrl,
  output logic                taken,
  output logic [PC_WIDTH-1:0] target,
  output logic                target_oob
);

  logic [PC_WIDTH-1:0] skip_target_c;

  // Skips are relative to the word after the control instruction, wrapping in pc width
  assign skip_target_c = dq_pc + PC_WIDTH'(1) + PC_WIDTH'(param);

  always_comb begin
    is_ctrl = is_ctrl_op(opcode);
    taken   = 1'b0;
    target  = skip_target_c;
    case (opcode)
      OP_GOTO: begin
        taken  = 1'b1;
        target = PC_WIDTH'(param);
      end
      OP_IFZ:  taken = flag_zero;
      OP_IFNZ: taken = ~flag_zero;
      OP_IFEQ: taken = flag_eq;
      default: taken = 1'b0;
    endcase
    target_oob = (32'(target) >= CMD_CNT);
  end

endmodule

// File: rtl/jac_fetch_seq.sv
// Fetch/sequencing stage: drives pc, decodes one word per cycle, resolves control flow locally
// and issues data-path instructions through a one-entry issue register.
module jac_fetch_seq
  import jac_pkg::*;
#(
  parameter int unsigned PC_WIDTH = 8,
  parameter int unsigned IRWidth  = 16,
  parameter int unsigned CMD_CNT  = 64
) (
  input  logic                clk,
  input  logic                res_n,
  input  logic [IRWidth-1:0]  ir,
  input  logic                flag_zero,
  input  logic                flag_eq,
  input  logic                exec_stall,
  output logic [PC_WIDTH-1:0] pc,
  output logic [IRWidth-1:0]  instr,
  output logic [PC_WIDTH-1:0] instr_pc,
  output logic                instr_valid,
  output logic                fault
);

  localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(CMD_CNT - 1);

  state_t              state;
  logic [IRWidth-1:0]  dq;
  logic [PC_WIDTH-1:0] dq_pc;
  logic                dq_v;

  logic [PC_WIDTH-1:0] pc_inc_c;
  logic                is_ctrl_c;
  logic                taken_c;
  logic [PC_WIDTH-1:0] target_c;
  logic                target_oob_c;

  assign pc_inc_c = (pc == PC_LAST) ? '0 : pc + PC_WIDTH'(1);

  jac_branch_cond #(
    .PC_WIDTH (PC_WIDTH),
    .CMD_CNT  (CMD_CNT)
  ) u_branch_cond (
    .opcode     (dq[OPC_MSB:OPC_LSB]),
    .param      (dq[PARAM_MSB:PARAM_LSB]),
    .dq_pc      (dq_pc),
    .flag_zero  (flag_zero),
    .flag_eq    (flag_eq),
    .is_ctrl    (is_ctrl_c),
    .taken      (taken_c),
    .target     (target_c),
    .target_oob (target_oob_c)
  );

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state       <= ST_START;
      pc          <= '0;
      dq          <= '0;
      dq_pc       <= '0;
      dq_v        <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      fault       <= 1'b0;
    end else begin
      case (state)
        ST_START: state <= ST_RUN;

        ST_RUN: begin
          if (!exec_stall) begin
            dq          <= ir;
            dq_pc       <= pc;
            dq_v        <= 1'b1;
            pc          <= pc_inc_c;
            instr_valid <= 1'b0;
            if (dq_v) begin
              if (!is_ctrl_c) begin
                instr       <= dq;
                instr_pc    <= dq_pc;
                instr_valid <= 1'b1;
              end else if (taken_c) begin
                // Taken control flow flushes the word fetched alongside it
                dq_v <= 1'b0;
                if (target_oob_c) begin
                  fault <= 1'b1;
                  state <= ST_HALT;
                  pc    <= pc;
                end else begin
                  pc <= target_c;
                end
              end
            end
          end
        end

        ST_HALT: instr_valid <= 1'b0;

        default: state <= ST_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_jac_fetch_seq.sv
// Directed bench for jac_fetch_seq: a per-cycle vector table for the branch/loop program and
// hand-written sequences for fault, stall and pc wrap.
module tb_jac_fetch_seq;

  logic        clk = 1'b0;
  logic        res_n = 1'b0;
  logic [15:0] ir;
  logic        flag_zero = 1'b0;
  logic        flag_eq = 1'b0;
  logic        exec_stall = 1'b0;
  logic [7:0]  pc;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        fault;

  logic [15:0] mem [0:255];
  int checks = 0;
  int errors = 0;

  typedef struct {
    bit stall;
    bit fz;
    bit feq;
    int e_pc;
    bit e_v;
    int e_ipc;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  assign ir = mem[pc];

  jac_fetch_seq #(
    .PC_WIDTH (8),
    .IRWidth  (16),
    .CMD_CNT  (64)
  ) dut (
    .clk         (clk),
    .res_n       (res_n),
    .ir          (ir),
    .flag_zero   (flag_zero),
    .flag_eq     (flag_eq),
    .exec_stall  (exec_stall),
    .pc          (pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .fault       (fault)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input int e_pc, input bit e_v, input int e_ipc,
                            input bit e_f);
    chk({tag, " pc"}, int'(pc), e_pc);
    chk({tag, " instr_valid"}, int'(instr_valid), int'(e_v));
    chk({tag, " fault"}, int'(fault), int'(e_f));
    if (e_v) begin
      chk({tag, " instr_pc"}, int'(instr_pc), e_ipc);
      chk({tag, " instr"}, int'(instr), int'(mem[e_ipc]));
    end
  endtask

  task automatic cyc(input bit s, input bit z, input bit e);
    exec_stall = s;
    flag_zero  = z;
    flag_eq    = e;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic do_reset(input string tag);
    exec_stall = 1'b0;
    flag_zero  = 1'b0;
    flag_eq    = 1'b0;
    @(negedge clk);
    res_n = 1'b0;
    @(negedge clk);
    chk({tag, " rst pc"}, int'(pc), 0);
    chk({tag, " rst instr_valid"}, int'(instr_valid), 0);
    chk({tag, " rst fault"}, int'(fault), 0);
    chk({tag, " rst instr"}, int'(instr), 0);
    chk({tag, " rst instr_pc"}, int'(instr_pc), 0);
    res_n = 1'b1;
  endtask

  function automatic void push(input int e_pc, input bit e_v, input int e_ipc);
    vec_t v;
    v.stall = 1'b0;
    v.fz    = 1'b0;
    v.feq   = 1'b0;
    v.e_pc  = e_pc;
    v.e_v   = e_v;
    v.e_ipc = e_ipc;
    vecs.push_back(v);
  endfunction

  // Stall with ifeq in D; the decision must use flag_eq from the first unstalled cycle
  task automatic stall_case(input bit fin);
    string tag;
    tag = fin ? "stall_taken" : "stall_fall";
    clear_mem();
    mem[0] = 16'h0801;
    mem[1] = 16'h9804;
    for (int i = 2; i < 10; i++) mem[i] = 16'h0800 | 16'(i);
    do_reset(tag);
    cyc(0, 0, 0); expect_out({tag, " e1"}, 0, 0, 0, 0);
    cyc(0, 0, 0); expect_out({tag, " e2"}, 1, 0, 0, 0);
    cyc(0, 0, 0); expect_out({tag, " e3"}, 2, 1, 0, 0);
    cyc(1, 0, ~fin); expect_out({tag, " stall1"}, 2, 1, 0, 0);
    cyc(1, 0, fin);  expect_out({tag, " stall2"}, 2, 1, 0, 0);
    cyc(1, 0, ~fin); expect_out({tag, " stall3"}, 2, 1, 0, 0);
    cyc(0, 0, fin);
    if (fin) begin
      expect_out({tag, " decide"}, 6, 0, 0, 0);
      cyc(0, 0, 0); expect_out({tag, " bubble"}, 7, 0, 0, 0);
      cyc(0, 0, 0); expect_out({tag, " target"}, 8, 1, 6, 0);
    end else begin
      expect_out({tag, " decide"}, 3, 0, 0, 0);
      cyc(0, 0, 0); expect_out({tag, " next"}, 4, 1, 2, 0);
      cyc(0, 0, 0); expect_out({tag, " next2"}, 5, 1, 3, 0);
    end
  endtask

  initial begin
    // Program: straight line, ifz skip 2 @10, ifnz skip 3 @15, goto 8 @27
    clear_mem();
    mem[0] = 16'h0801; mem[1] = 16'h0802; mem[2] = 16'h0803; mem[3] = 16'h1000;
    mem[10] = 16'h8802;
    mem[15] = 16'h9003;
    mem[16] = 16'h08AA; mem[17] = 16'h08AB; mem[18] = 16'h08AC;
    mem[19] = 16'h1013;
    mem[27] = 16'h8008;

    push(0, 0, 0);
    push(1, 0, 0);
    for (int k = 3; k <= 12; k++) push(k - 1, 1, k - 3);
    push(12, 0, 0);
    for (int k = 14; k <= 17; k++) push(k - 1, 1, k - 3);
    push(19, 0, 0);
    push(20, 0, 0);
    for (int k = 20; k <= 27; k++) push(k + 1, 1, k - 1);
    for (int lp = 0; lp < 3; lp++) begin
      push(8, 0, 0);
      push(9, 0, 0);
      push(10, 1, 8);
      push(11, 1, 9);
      push(12, 0, 0);
      for (int i = 0; i < 4; i++) push(13 + i, 1, 11 + i);
      push(19, 0, 0);
      push(20, 0, 0);
      for (int i = 0; i < 8; i++) push(21 + i, 1, 19 + i);
    end

    do_reset("prog");
    foreach (vecs[i]) begin
      cyc(vecs[i].stall, vecs[i].fz, vecs[i].feq);
      expect_out($sformatf("prog e%0d", i + 1), vecs[i].e_pc, vecs[i].e_v, vecs[i].e_ipc, 1'b0);
    end

    // Out-of-range goto: fault, HALT, frozen pc, then asynchronous reset recovery
    clear_mem();
    mem[0] = 16'h0801;
    mem[1] = 16'h8046;
    for (int i = 2; i < 8; i++) mem[i] = 16'h0802;
    do_reset("oob");
    cyc(0, 0, 0); expect_out("oob e1", 0, 0, 0, 0);
    cyc(0, 0, 0); expect_out("oob e2", 1, 0, 0, 0);
    cyc(0, 0, 0); expect_out("oob e3", 2, 1, 0, 0);
    cyc(0, 0, 0); expect_out("oob fault", 2, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cyc(i[0], i[1], 0);
      expect_out($sformatf("oob halt%0d", i), 2, 0, 0, 1);
    end
    #2 res_n = 1'b0;
    #1;
    chk("oob async pc", int'(pc), 0);
    chk("oob async fault", int'(fault), 0);
    chk("oob async instr_valid", int'(instr_valid), 0);
    @(negedge clk);
    res_n = 1'b1;
    cyc(0, 0, 0); expect_out("oob re e1", 0, 0, 0, 0);
    cyc(0, 0, 0); expect_out("oob re e2", 1, 0, 0, 0);

    stall_case(1'b0);
    stall_case(1'b1);

    // pc wrap from 63 to 0 on a non-control word
    clear_mem();
    mem[0]  = 16'h803D;
    mem[61] = 16'h083D;
    mem[62] = 16'h083E;
    mem[63] = 16'h083F;
    do_reset("wrap");
    cyc(0, 0, 0); expect_out("wrap e1", 0, 0, 0, 0);
    cyc(0, 0, 0); expect_out("wrap e2", 1, 0, 0, 0);
    cyc(0, 0, 0); expect_out("wrap goto", 61, 0, 0, 0);
    cyc(0, 0, 0); expect_out("wrap bubble", 62, 0, 0, 0);
    cyc(0, 0, 0); expect_out("wrap i61", 63, 1, 61, 0);
    cyc(0, 0, 0); expect_out("wrap i62", 0, 1, 62, 0);
    cyc(0, 0, 0); expect_out("wrap i63", 1, 1, 63, 0);
    cyc(0, 0, 0); expect_out("wrap goto2", 61, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
